// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the ID -> RR -> EX pipeline
package pipeline_pkg;

  localparam int NUM_GPR = 16;
  localparam int IDX_W   = 4;
  localparam int RSP_GPR = 4;
  localparam int XLEN    = 64;

  localparam logic [7:0] OP_PUSH_LO = 8'd80;
  localparam logic [7:0] OP_PUSH_HI = 8'd87;
  localparam logic [7:0] OP_POP_LO  = 8'd88;
  localparam logic [7:0] OP_POP_HI  = 8'd95;
  localparam logic [7:0] OP_CALL    = 8'd232;
  localparam logic [7:0] OP_RET     = 8'd195;
  localparam logic [7:0] OP_MUL     = 8'd247;

  typedef logic [0:XLEN-1] gpr_t;
  typedef gpr_t regfile_t [0:NUM_GPR-1];

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} rr_state_t;

  typedef struct packed {
    logic [7:0]         opcode;
    logic               twob;
    logic [IDX_W-1:0]   reg_byte;
    logic [IDX_W-1:0]   rm_byte;
    logic               src_a_en;
    logic               src_b_en;
    logic               use_rsp;
    logic [NUM_GPR-1:0] dst_mask;
  } id_rr_t;

  typedef struct packed {
    logic [7:0]         opcode;
    logic               twob;
    logic [IDX_W-1:0]   reg_byte;
    logic [IDX_W-1:0]   rm_byte;
    logic [XLEN-1:0]    op_a;
    logic [XLEN-1:0]    op_b;
    logic [XLEN-1:0]    rsp;
    logic [NUM_GPR-1:0] dst_mask;
  } rr_ex_t;

  function automatic logic is_stack_op(input logic [7:0] op);
    return (op >= OP_PUSH_LO && op <= OP_POP_HI) || op == OP_CALL || op == OP_RET;
  endfunction

endpackage

// File: rtl/mod_scoreboard.sv
// rtl/mod_scoreboard.sv - per-register pending-write counters with RAW/WAW hazard detection
module mod_scoreboard
  import pipeline_pkg::*;
#(
  parameter int NREGS   = NUM_GPR,
  parameter int PEND_W  = 2,
  parameter int RSP_IDX = RSP_GPR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             accept,
  input  logic [NREGS-1:0] inc_mask,
  input  logic             src_a_en,
  input  logic [IDX_W-1:0] src_a_idx,
  input  logic             src_b_en,
  input  logic [IDX_W-1:0] src_b_idx,
  input  logic             use_rsp,
  input  logic             wb_retire,
  input  logic [NREGS-1:0] wb_dst_mask,
  input  logic             wb_byp_en,
  input  logic [IDX_W-1:0] wb_byp_idx,
  input  logic             undo,
  input  logic [NREGS-1:0] undo_mask,
  output logic             hazard,
  output logic             all_clear,
  output logic             sb_error
);

  localparam logic [PEND_W-1:0] PEND_MAX   = '1;
  localparam logic [PEND_W+1:0] PEND_MAX_X = {2'b00, PEND_MAX};

  logic [PEND_W-1:0] pend     [NREGS];
  logic [PEND_W-1:0] pend_nxt [NREGS];
  logic              err_nxt;

  // A source with exactly one pending write is usable when that write retires and bypasses now.
  always_comb begin
    hazard    = 1'b0;
    all_clear = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      if ((src_a_en && src_a_idx == IDX_W'(i)) || (src_b_en && src_b_idx == IDX_W'(i)) ||
          (use_rsp && i == RSP_IDX)) begin
        if (pend[i] != '0 &&
            !(pend[i] == PEND_W'(1) && wb_retire && wb_dst_mask[i] && wb_byp_en &&
              wb_byp_idx == IDX_W'(i)))
          hazard = 1'b1;
      end
      if (inc_mask[i] && pend[i] == PEND_MAX) hazard = 1'b1;
      if (pend[i] != '0) all_clear = 1'b0;
    end
  end

  always_comb begin
    logic [PEND_W+1:0] up;
    logic [PEND_W+1:0] dn;
    up      = '0;
    dn      = '0;
    err_nxt = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      pend_nxt[i] = pend[i];
      up = {2'b00, pend[i]} + (PEND_W+2)'(accept && inc_mask[i]);
      dn = (PEND_W+2)'(wb_retire && wb_dst_mask[i]) + (PEND_W+2)'(undo && undo_mask[i]);
      if (up < dn) begin
        pend_nxt[i] = '0;
        err_nxt     = 1'b1;
      end else if (up - dn > PEND_MAX_X) begin
        pend_nxt[i] = PEND_MAX;
        err_nxt     = 1'b1;
      end else begin
        pend_nxt[i] = PEND_W'(up - dn);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) pend[i] <= '0;
      sb_error <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) pend[i] <= pend_nxt[i];
      if (err_nxt) sb_error <= 1'b1;
    end
  end

endmodule

// File: rtl/mod_regread.sv
// rtl/mod_regread.sv - register-read/issue stage: operand read, bypass, issue register, flush drain FSM
module mod_regread
  import pipeline_pkg::*;
#(
  parameter int NREGS   = NUM_GPR,
  parameter int PEND_W  = 2,
  parameter int RSP_IDX = RSP_GPR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [7:0]       id_opcode,
  input  logic             id_twob,
  input  logic [IDX_W-1:0] id_regByte,
  input  logic [IDX_W-1:0] id_rmByte,
  input  logic             id_src_a_en,
  input  logic             id_src_b_en,
  input  logic             id_use_rsp,
  input  logic [NREGS-1:0] id_dst_mask,
  input  gpr_t             regfile [0:NREGS-1],
  input  logic             wb_retire,
  input  logic [NREGS-1:0] wb_dst_mask,
  input  logic             wb_byp_en,
  input  logic [IDX_W-1:0] wb_byp_idx,
  input  logic [XLEN-1:0]  wb_byp_data,
  input  logic             flush,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [7:0]       ex_opcode,
  output logic             ex_twob,
  output logic [IDX_W-1:0] ex_regByte,
  output logic [IDX_W-1:0] ex_rmByte,
  output logic [XLEN-1:0]  ex_op_a,
  output logic [XLEN-1:0]  ex_op_b,
  output logic [XLEN-1:0]  ex_rsp,
  output logic [NREGS-1:0] ex_dst_mask,
  output logic [31:0]      stall_count,
  output logic             sb_error
);

  rr_state_t state_q, state_d;
  id_rr_t    id_pkt;
  rr_ex_t    iss, ex_q;
  logic      hazard, all_clear, accept;

  assign id_pkt = '{opcode: id_opcode, twob: id_twob, reg_byte: id_regByte, rm_byte: id_rmByte,
                    src_a_en: id_src_a_en, src_b_en: id_src_b_en, use_rsp: id_use_rsp,
                    dst_mask: id_dst_mask};

  assign id_ready = !reset && state_q == RUN && !hazard && (!ex_valid || ex_ready) && !flush;
  assign accept   = id_valid && id_ready;

  // Same-cycle writeback wins over the (not yet updated) register file.
  always_comb begin
    iss          = '0;
    iss.opcode   = id_pkt.opcode;
    iss.twob     = id_pkt.twob;
    iss.reg_byte = id_pkt.reg_byte;
    iss.rm_byte  = id_pkt.rm_byte;
    iss.dst_mask = id_pkt.dst_mask;
    if (id_pkt.src_a_en)
      iss.op_a = (wb_byp_en && wb_byp_idx == id_pkt.reg_byte) ? wb_byp_data : regfile[id_pkt.reg_byte];
    if (id_pkt.src_b_en)
      iss.op_b = (wb_byp_en && wb_byp_idx == id_pkt.rm_byte) ? wb_byp_data : regfile[id_pkt.rm_byte];
    if (id_pkt.use_rsp)
      iss.rsp = (wb_byp_en && wb_byp_idx == IDX_W'(RSP_IDX)) ? wb_byp_data : regfile[RSP_IDX];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush) state_d = DRAIN;
      DRAIN:   if (!flush && all_clear) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      ex_valid    <= 1'b0;
      ex_q        <= '0;
      stall_count <= '0;
    end else begin
      state_q <= state_d;
      if (id_valid && !id_ready) stall_count <= stall_count + 32'd1;
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (accept) begin
        ex_valid <= 1'b1;
        ex_q     <= iss;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

  assign ex_opcode   = ex_q.opcode;
  assign ex_twob     = ex_q.twob;
  assign ex_regByte  = ex_q.reg_byte;
  assign ex_rmByte   = ex_q.rm_byte;
  assign ex_op_a     = ex_q.op_a;
  assign ex_op_b     = ex_q.op_b;
  assign ex_rsp      = ex_q.rsp;
  assign ex_dst_mask = ex_q.dst_mask;

  // A squashed packet will never retire, so its pending writes are returned here.
  mod_scoreboard #(.NREGS(NREGS), .PEND_W(PEND_W), .RSP_IDX(RSP_IDX)) u_sb (
    .clk         (clk),
    .reset       (reset),
    .accept      (accept),
    .inc_mask    (id_pkt.dst_mask),
    .src_a_en    (id_pkt.src_a_en),
    .src_a_idx   (id_pkt.reg_byte),
    .src_b_en    (id_pkt.src_b_en),
    .src_b_idx   (id_pkt.rm_byte),
    .use_rsp     (id_pkt.use_rsp),
    .wb_retire   (wb_retire),
    .wb_dst_mask (wb_dst_mask),
    .wb_byp_en   (wb_byp_en),
    .wb_byp_idx  (wb_byp_idx),
    .undo        (flush && ex_valid),
    .undo_mask   (ex_q.dst_mask),
    .hazard      (hazard),
    .all_clear   (all_clear),
    .sb_error    (sb_error)
  );

endmodule

// File: tb/tb_mod_regread.sv
// tb/tb_mod_regread.sv - directed vector bench for mod_regread
module tb_mod_regread;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        reset, id_valid, id_ready, id_twob, id_src_a_en, id_src_b_en, id_use_rsp;
  logic [7:0]  id_opcode;
  logic [3:0]  id_regByte, id_rmByte, wb_byp_idx, ex_regByte, ex_rmByte;
  logic [15:0] id_dst_mask, wb_dst_mask, ex_dst_mask;
  gpr_t        rf [0:15];
  logic        wb_retire, wb_byp_en, flush, ex_valid, ex_ready, ex_twob, sb_error;
  logic [63:0] wb_byp_data, ex_op_a, ex_op_b, ex_rsp;
  logic [7:0]  ex_opcode;
  logic [31:0] stall_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mod_regread dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_twob(id_twob), .id_regByte(id_regByte), .id_rmByte(id_rmByte),
    .id_src_a_en(id_src_a_en), .id_src_b_en(id_src_b_en), .id_use_rsp(id_use_rsp),
    .id_dst_mask(id_dst_mask), .regfile(rf), .wb_retire(wb_retire), .wb_dst_mask(wb_dst_mask),
    .wb_byp_en(wb_byp_en), .wb_byp_idx(wb_byp_idx), .wb_byp_data(wb_byp_data), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode), .ex_twob(ex_twob),
    .ex_regByte(ex_regByte), .ex_rmByte(ex_rmByte), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_rsp(ex_rsp), .ex_dst_mask(ex_dst_mask), .stall_count(stall_count), .sb_error(sb_error)
  );

  typedef struct {
    logic [7:0]  op;
    logic        twob;
    logic [3:0]  ra;
    logic        a_en;
    logic [3:0]  rb;
    logic        b_en;
    logic        rsp;
    logic        byp_en;
    logic [3:0]  byp_idx;
    logic [63:0] byp_data;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    logic [63:0] exp_rsp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_opcode = 0; id_twob = 0; id_regByte = 0; id_rmByte = 0;
    id_src_a_en = 0; id_src_b_en = 0; id_use_rsp = 0; id_dst_mask = 0;
  endtask

  task automatic clear_wb();
    wb_retire = 0; wb_dst_mask = 0; wb_byp_en = 0; wb_byp_idx = 0; wb_byp_data = 0;
  endtask

  task automatic issue(input logic [7:0] op, input logic [3:0] ra, input logic a_en,
                       input logic [3:0] rb, input logic b_en, input logic rsp,
                       input logic [15:0] dst);
    id_valid = 1; id_opcode = op; id_twob = 0; id_regByte = ra; id_src_a_en = a_en;
    id_rmByte = rb; id_src_b_en = b_en; id_use_rsp = rsp; id_dst_mask = dst;
  endtask

  task automatic do_reset();
    reset = 1; flush = 0; ex_ready = 1;
    clear_id(); clear_wb();
    issue(8'h01, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0);
    step();
    check("rst_id_ready", id_ready, 0);
    step();
    reset = 0;
    clear_id();
    #1;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_stall_count", stall_count, 0);
    check("rst_sb_error", sb_error, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 64'h00C0FFEE00000000 + 64'(i);

    vecs[0] = '{8'h01, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 64'h0,
                64'h00C0FFEE00000001, 64'h00C0FFEE00000002, 64'h0};
    vecs[1] = '{8'h50, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 64'h0,
                64'h00C0FFEE00000000, 64'h0, 64'h00C0FFEE00000004};
    vecs[2] = '{8'hC3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd4, 64'h1234,
                64'h0, 64'h0, 64'h1234};
    vecs[3] = '{8'hF7, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 4'd5, 64'hBEEF000000000005,
                64'hBEEF000000000005, 64'hBEEF000000000005, 64'h0};
    vecs[4] = '{8'h01, 1'b0, 4'd15, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 4'd7, 64'hFFFFFFFFFFFFFFFF,
                64'h00C0FFEE0000000F, 64'h00C0FFEE00000000, 64'h0};
    vecs[5] = '{8'h90, 1'b0, 4'd9, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1, 4'd9, 64'hFFFFFFFFFFFFFFFF,
                64'h0, 64'h0, 64'h0};

    do_reset();

    // operand read / bypass vectors, issued back to back
    for (int v = 0; v < 6; v++) begin
      issue(vecs[v].op, vecs[v].ra, vecs[v].a_en, vecs[v].rb, vecs[v].b_en, vecs[v].rsp, 16'h0);
      id_twob = vecs[v].twob;
      wb_byp_en = vecs[v].byp_en; wb_byp_idx = vecs[v].byp_idx; wb_byp_data = vecs[v].byp_data;
      #1;
      check($sformatf("v%0d_id_ready", v), id_ready, 1);
      step();
      check($sformatf("v%0d_ex_valid", v), ex_valid, 1);
      check($sformatf("v%0d_opcode", v), ex_opcode, vecs[v].op);
      check($sformatf("v%0d_twob", v), ex_twob, vecs[v].twob);
      check($sformatf("v%0d_op_a", v), ex_op_a, vecs[v].exp_a);
      check($sformatf("v%0d_op_b", v), ex_op_b, vecs[v].exp_b);
      check($sformatf("v%0d_rsp", v), ex_rsp, vecs[v].exp_rsp);
    end
    clear_id(); clear_wb();
    step();
    check("vec_drain_ex_valid", ex_valid, 0);

    // RAW hazard released by a bypassing retirement
    do_reset();
    issue(8'h01, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0001);
    step();
    issue(8'h02, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0);
    #1;
    check("raw_stall", id_ready, 0);
    step(); step(); step();
    check("raw_stall_count", stall_count, 3);
    wb_retire = 1; wb_dst_mask = 16'h0001; wb_byp_en = 1; wb_byp_idx = 0; wb_byp_data = 64'hDEAD;
    #1;
    check("raw_bypass_ready", id_ready, 1);
    step();
    clear_id(); clear_wb();
    check("raw_ex_valid", ex_valid, 1);
    check("raw_op_a", ex_op_a, 64'hDEAD);
    check("raw_stall_hold", stall_count, 3);

    // pending-write counter saturation
    do_reset();
    for (int k = 0; k < 3; k++) begin
      issue(8'h50, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0010);
      #1;
      check($sformatf("sat_push%0d_ready", k), id_ready, 1);
      step();
    end
    #1;
    check("sat_fourth_stall", id_ready, 0);
    wb_retire = 1; wb_dst_mask = 16'h0010;
    #1;
    check("sat_retire_same_cycle", id_ready, 0);
    step();
    clear_wb();
    #1;
    check("sat_after_retire", id_ready, 1);
    step();
    check("sat_full_again", id_ready, 0);
    check("sat_no_error", sb_error, 0);
    clear_id();

    // backpressure holds the packet, release gives back-to-back issue
    do_reset();
    ex_ready = 0;
    issue(8'h01, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0);
    step();
    issue(8'h02, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0);
    #1;
    check("hold_id_ready", id_ready, 0);
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("hold%0d_valid", c), ex_valid, 1);
      check($sformatf("hold%0d_opcode", c), ex_opcode, 8'h01);
      check($sformatf("hold%0d_op_a", c), ex_op_a, 64'h00C0FFEE00000001);
    end
    ex_ready = 1;
    #1;
    check("hold_release_ready", id_ready, 1);
    step();
    clear_id();
    check("b2b_valid", ex_valid, 1);
    check("b2b_opcode", ex_opcode, 8'h02);
    check("b2b_op_a", ex_op_a, 64'h00C0FFEE00000002);
    step();
    check("b2b_drained", ex_valid, 0);

    // flush squashes in-flight packet, drain until outstanding writes retire
    do_reset();
    issue(8'h10, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0002);
    step();
    issue(8'h11, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0008);
    step();
    issue(8'h12, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0004);
    step();
    clear_id();
    ex_ready = 0;
    flush = 1;
    step();
    flush = 0;
    ex_ready = 1;
    issue(8'h20, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0);
    #1;
    check("flush_ex_valid", ex_valid, 0);
    check("flush_drain_ready", id_ready, 0);
    wb_retire = 1; wb_dst_mask = 16'h0002;
    step();
    wb_dst_mask = 16'h0008;
    step();
    clear_wb();
    #1;
    check("drain_last_clear", id_ready, 0);
    step();
    check("drain_exit_ready", id_ready, 1);
    check("drain_no_error", sb_error, 0);
    clear_id();

    // underflow sets the sticky error
    do_reset();
    wb_retire = 1; wb_dst_mask = 16'h0100;
    step();
    clear_wb();
    check("underflow_error", sb_error, 1);
    step(); step();
    check("underflow_sticky", sb_error, 1);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_regread.md
Name: mod_regread

Overview:
- Register-read/issue stage: the reader side of the architectural register file that the writeback stage writes.
- Accepts decoded instructions from ID and reads up to two source operands plus RSP.
- Holds a per-register pending-write scoreboard, so RAW/WAW hazards against in-flight writebacks are blocked.
- Forwards same-cycle writeback data and presents a registered issue packet to EX over a valid/ready handshake.

Parameters:
- NREGS, 16, architectural GPR count (regfile index 0..NREGS-1)
- PEND_W, 2, width of each per-register pending-write counter (max outstanding = 2^PEND_W-1 = 3)
- RSP_IDX, 4, regfile index of the stack pointer

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  decoded instruction available
- id_ready  out  1  stage accepts instruction this cycle
- id_opcode  in  8  primary opcode
- id_twob  in  1  two-byte opcode flag
- id_regByte  in  4  ModRM reg field
- id_rmByte  in  4  ModRM rm field
- id_src_a_en  in  1  operand A read enable (index = id_regByte)
- id_src_b_en  in  1  operand B read enable (index = id_rmByte)
- id_use_rsp  in  1  instruction reads RSP (push/pop/call/ret)
- id_dst_mask  in  16  registers this instruction will write (bit i = reg i)
- regfile  in  16x64  architectural register array, [0:63] regfile[0:15]
- wb_retire  in  1  writeback completed an instruction this cycle
- wb_dst_mask  in  16  registers released by that retirement
- wb_byp_en  in  1  single-register write occurring this cycle
- wb_byp_idx  in  4  its index
- wb_byp_data  in  64  its value
- flush  in  1  squash the issue register (branch redirect)
- ex_valid  out  1  issue packet valid
- ex_ready  in  1  EX accepts packet
- ex_opcode  out  8, ex_twob out 1, ex_regByte out 4, ex_rmByte out 4  passed through
- ex_op_a  out  64, ex_op_b out 64, ex_rsp out 64  operand values
- ex_dst_mask  out  16  passed through
- stall_count  out  32  cycles with id_valid=1 and id_ready=0
- sb_error  out  1  sticky: counter underflow or overflow attempted

Behaviour:
- Reset (sync, clk edge with reset=1):
  - all counters = 0; ex_valid = 0; all ex_* data = 0; stall_count = 0; sb_error = 0; state = RUN.
  - Reset has priority over every other input.
- Source set S = {regByte if src_a_en, rmByte if src_b_en, RSP_IDX if use_rsp}.
- Source s is ready if pend[s]==0, OR pend[s]==1 && wb_retire && wb_dst_mask[s] && wb_byp_en && wb_byp_idx==s (bypass).
- hazard = any s in S not ready, OR any d in id_dst_mask with pend[d]==3 (saturation).
- id_ready = (state==RUN) && !hazard && (!ex_valid || ex_ready) && !flush.
- Accept (id_valid && id_ready):
  - Issue register loads on the next edge; latency 1 cycle, ex_valid=1.
  - Operand value = wb_byp_data when bypass matches that index, else regfile[idx].
  - Disabled operands read as 0.
- Handshake: ex_valid && !ex_ready holds every ex_* output stable. Packet leaves on ex_valid && ex_ready; ex_valid drops unless a new accept occurs in the same cycle (back-to-back, 1/cycle throughput).
- Scoreboard update, per register i: pend[i] <= pend[i] + (accept && id_dst_mask[i]) - (wb_retire && wb_dst_mask[i]).
  - Simultaneous inc+dec leaves the counter unchanged.
  - Decrement at 0: counter stays 0 and sb_error=1.
  - Increment at 3 cannot happen (hazard); if forced, saturate and set sb_error=1.
- FSM:
  - RUN: normal operation.
    - flush -> DRAIN; ex_valid <= 0 next edge.
    - The squashed packet's dst bits are decremented (undo) on the flush edge.
  - DRAIN: id_ready=0; retirements continue to decrement. When all pend==0 -> RUN (next edge).
  - flush while in DRAIN: stays in DRAIN.
- stall_count: increments while id_valid && !id_ready, wraps at 2^32-1 -> 0.

Decomposition:
- Shared package (e.g. pipeline_pkg) holds:
  - ID_RR and RR_EX packed structs;
  - regfile typedef [0:63] [0:15];
  - RSP index, NREGS;
  - opcode constants (PUSH 80-87, POP 88-95, CALL 232, RET 195, MUL 247).
- One sub-module: mod_scoreboard, holding the counters, ready/hazard logic and sb_error. The issue register, bypass mux and FSM stay in mod_regread.

Test Plan:
- Reset with id_valid=1 held -> id_ready=0 during reset; after reset all pend=0, ex_valid=0, stall_count=0.
- Accept dst_mask=0x0001 (RAX); next instr reads RAX with no retire -> id_ready=0 and stall_count increments each cycle. Then wb_retire mask 0x0001 with wb_byp_idx=0, data=0xDEAD -> accepted that cycle, ex_op_a=0xDEAD one cycle later.
- Three pushes (dst_mask 0x0010) without retire -> pend[4]=3. Fourth push -> stalled; a single retire of 0x0010 -> accepted, pend[4] stays 3.
- ex_ready=0 with ex_valid=1 for 5 cycles -> ex_* stable; ex_ready=1 with id_valid=1 -> new packet on the next edge, no bubble.
- flush with an in-flight packet dst 0x0004 -> ex_valid=0 next cycle, state DRAIN. Two outstanding retires release everything -> RUN one cycle after last pend clears.
- wb_retire mask 0x0100 while pend[8]=0 -> sb_error=1 and stays 1 until reset.
